// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops the TX FIFO head and shifts it out as start/data/[parity]/stop.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen per frame by parity_odd).
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  tx_en,
    input  logic [DIV_WIDTH-1:0]  divisor,
    input  logic                  parity_odd,
    input  logic                  f_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  baud_q;
    logic [BW-1:0]         bit_q;
    logic                  stop_q;
    logic                  txd_q;
    logic                  rd_en_q;
    logic                  busy_q;
    logic                  done_q;
`ifdef UART_TX_PARITY_EN
    logic                  par_q;
`else
    logic                  unused_parity;
    assign unused_parity = parity_odd;
`endif

    logic bit_end;
    logic last_data;
    logic last_stop;
    logic frame_end;
    logic launch;

    assign bit_end   = (baud_q == div_q);
    assign last_data = (bit_q == BW'(DATA_WIDTH - 1));
    assign last_stop = (stop_q == 1'(STOP_BITS - 1));
    assign frame_end = (state_q == STOP) && bit_end && last_stop;
    // A new frame may start from IDLE or directly out of the final stop cycle.
    assign launch    = tx_en && !f_empty && ((state_q == IDLE) || frame_end);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= frame_end;
            if (launch) begin
                shreg_q <= rd_data;
                div_q   <= divisor;
                baud_q  <= '0;
                bit_q   <= '0;
                stop_q  <= 1'b0;
                txd_q   <= 1'b0;
                rd_en_q <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= START;
`ifdef UART_TX_PARITY_EN
                par_q   <= parity_odd;
`endif
            end else if (state_q != IDLE) begin
                if (!bit_end) begin
                    baud_q <= baud_q + DIV_WIDTH'(1);
                end else begin
                    baud_q <= '0;
                    case (state_q)
                        START: begin
                            state_q <= DATA;
                            txd_q   <= shreg_q[0];
                        end
                        DATA: begin
                            shreg_q <= shreg_q >> 1;
`ifdef UART_TX_PARITY_EN
                            par_q   <= par_q ^ shreg_q[0];
`endif
                            if (last_data) begin
                                bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                                state_q <= PARITY;
                                txd_q   <= par_q ^ shreg_q[0];
`else
                                state_q <= STOP;
                                txd_q   <= 1'b1;
`endif
                            end else begin
                                bit_q <= bit_q + BW'(1);
                                txd_q <= shreg_q[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end
`endif
                        STOP: begin
                            if (last_stop) begin
                                stop_q  <= 1'b0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                txd_q   <= 1'b1;
                            end else begin
                                stop_q <= stop_q + 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign rd_en   = rd_en_q;
    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames, a negedge monitor checks txd bit by bit.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
    localparam int LEN_D1 = 22;
    localparam int LEN_D3 = 44;
    localparam int LEN_D7 = 88;
`else
    localparam int NBITS  = 10;
    localparam int LEN_D1 = 20;
    localparam int LEN_D3 = 40;
    localparam int LEN_D7 = 80;
`endif

    logic        clk;
    logic        n_rst;
    logic        tx_en;
    logic [15:0] divisor;
    logic        parity_odd;
    logic        f_empty;
    logic [7:0]  rd_data;
    logic        rd_en;
    logic        txd;
    logic        busy;
    logic        tx_done;

    uart_tx_serializer #(.DATA_WIDTH(8), .DIV_WIDTH(16), .STOP_BITS(1)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_en      (tx_en),
        .divisor    (divisor),
        .parity_odd (parity_odd),
        .f_empty    (f_empty),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bits[i] is the i-th level on the line (start first), div is the divisor in force at launch
    typedef struct {
        logic [11:0] bits;
        int          div;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];

    int tests = 0;
    int fails = 0;
    int n_pops = 0;
    int n_done = 0;
    int cyc = 0;
    int pop_cyc_last = 0;
    int pop_cyc_prev = 0;
    int done_cyc = 0;

    task automatic chk1(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [11:0] bits_np,
                        input logic [11:0] bits_par, input int div);
        exp_t e;
`ifdef UART_TX_PARITY_EN
        e.bits = bits_par;
`else
        e.bits = bits_np;
`endif
        e.div = div;
        exp_q.push_back(e);
        fifo.push_back(d);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) @(posedge clk);
        chki("wait_tx_done", (n_done >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_pop(input int target, input int budget);
        for (int i = 0; i < budget && n_pops < target; i++) @(posedge clk);
        chki("wait_rd_en", (n_pops >= target) ? 1 : 0, 1);
    endtask

    // Show-ahead FIFO model: pops on the edge after rd_en is seen
    bit pop_req;
    initial begin
        f_empty = 1'b1;
        rd_data = '0;
        pop_req = 1'b0;
        forever begin
            @(negedge clk);
            pop_req = rd_en;
            @(posedge clk);
            #1;
            if (pop_req && fifo.size() > 0) void'(fifo.pop_front());
            f_empty = (fifo.size() == 0);
            rd_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
    end

    exp_t cur;
    int   t = 0;
    int   cur_len = 0;
    bit   active = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!n_rst) begin
                active = 1'b0;
                chk1("rst_txd", txd, 1'b1);
                chk1("rst_rd_en", rd_en, 1'b0);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_tx_done", tx_done, 1'b0);
            end else begin
                if (active) begin
                    t++;
                    if (t < cur_len) begin
                        chk1("txd_bit", txd, cur.bits[t / (cur.div + 1)]);
                        chk1("busy_frame", busy, 1'b1);
                        chk1("rd_en_once", rd_en, 1'b0);
                        chk1("tx_done_early", tx_done, 1'b0);
                    end else begin
                        chk1("tx_done_end", tx_done, 1'b1);
                        if (tx_done) begin
                            n_done++;
                            done_cyc = cyc;
                        end
                        active = 1'b0;
                        if (!rd_en) begin
                            chk1("busy_fall", busy, 1'b0);
                            chk1("idle_txd_end", txd, 1'b1);
                        end
                    end
                end else begin
                    chk1("idle_tx_done", tx_done, 1'b0);
                    if (!rd_en) begin
                        chk1("idle_txd", txd, 1'b1);
                        chk1("idle_busy", busy, 1'b0);
                    end
                end
                if (rd_en && !active) begin
                    n_pops++;
                    pop_cyc_prev = pop_cyc_last;
                    pop_cyc_last = cyc;
                    chki("expect_avail", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) begin
                        cur     = exp_q.pop_front();
                        active  = 1'b1;
                        t       = 0;
                        cur_len = NBITS * (cur.div + 1);
                        chk1("start_bit", txd, 1'b0);
                        chk1("busy_rise", busy, 1'b1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p0;
    int d0;

    initial begin
        n_rst      = 1'b0;
        tx_en      = 1'b0;
        divisor    = 16'd3;
        parity_odd = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single frame 0xA5, 4-cycle bits
        tx_en = 1'b1;
        push(8'hA5, 12'b0011_0100_1010, 12'b0101_0100_1010, 3);
        wait_done(1, 200);
        chki("single_pops", n_pops, 1);
        chki("single_len", done_cyc - pop_cyc_last, LEN_D3);
        repeat (3) @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b1;
        d0 = n_done;
        push(8'hA5, 12'b0011_0100_1010, 12'b0111_0100_1010, 3);
        wait_done(d0 + 1, 200);
        chki("odd_par_len", done_cyc - pop_cyc_last, LEN_D3);
        #1 parity_odd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`endif

        // back-to-back 0x00 then 0xFF, 2-cycle bits
        tx_en   = 1'b0;
        divisor = 16'd1;
        p0 = n_pops;
        d0 = n_done;
        push(8'h00, 12'b0010_0000_0000, 12'b0100_0000_0000, 1);
        push(8'hFF, 12'b0011_1111_1110, 12'b0101_1111_1110, 1);
        repeat (2) @(posedge clk);
        #1 tx_en = 1'b1;
        wait_done(d0 + 2, 200);
        chki("b2b_pops", n_pops - p0, 2);
        chki("b2b_spacing", pop_cyc_last - pop_cyc_prev, LEN_D1);
        chki("b2b_dones", n_done - d0, 2);

        // empty FIFO with tx_en high
        p0 = n_pops;
        repeat (100) @(posedge clk);
        #1;
        chki("empty_no_pop", n_pops, p0);
        chk1("empty_busy", busy, 1'b0);

        // tx_en drop and divisor change during DATA bit 2
        divisor = 16'd3;
        p0 = n_pops;
        d0 = n_done;
        push(8'h3C, 12'b0010_0111_1000, 12'b0100_0111_1000, 3);
        wait_pop(p0 + 1, 50);
        repeat (12) @(posedge clk);
        #1;
        tx_en   = 1'b0;
        divisor = 16'd7;
        push(8'h81, 12'b0011_0000_0010, 12'b0101_0000_0010, 7);
        wait_done(d0 + 1, 200);
        chki("midframe_len", done_cyc - pop_cyc_last, LEN_D3);
        repeat (60) @(posedge clk);
        #1;
        chki("txen0_no_pop", n_pops, p0 + 1);
        tx_en = 1'b1;
        wait_done(d0 + 2, 300);
        chki("div7_len", done_cyc - pop_cyc_last, LEN_D7);

        // asynchronous reset during DATA bit 4
        divisor = 16'd3;
        p0 = n_pops;
        push(8'h5A, 12'b0010_1011_0100, 12'b0100_1011_0100, 3);
        wait_pop(p0 + 1, 50);
        repeat (20) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk1("async_rst_txd", txd, 1'b1);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_rd_en", rd_en, 1'b0);
        push(8'hC3, 12'b0011_1000_0110, 12'b0101_1000_0110, 3);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        d0 = n_done;
        wait_done(d0 + 1, 200);
        chki("post_rst_pops", n_pops - p0, 2);
        chki("post_rst_len", done_cyc - pop_cyc_last, LEN_D3);

        repeat (5) @(posedge clk);
        #1;
        chki("exp_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit stage downstream of the TX FIFO. It pops one entry at a time and serialises it onto txd as an asynchronous UART frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, then STOP_BITS stop bits.
- Drives the FIFO pop strobe (the FIFO's can_read) and consumes the FIFO's f_empty status.
- Bit timing comes from an internal divisor counter. No external baud tick is used.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- DIV_WIDTH, 16, width of the divisor input and the internal bit-period counter.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  clock.
- n_rst  input  1  reset; asynchronous, active-low.
- tx_en  input  1  transmit enable; when 0, no new frame starts.
- divisor  input  DIV_WIDTH  bit period = divisor+1 clk cycles.
- parity_odd  input  1  parity sense, 1 = odd, 0 = even; ignored when UART_TX_PARITY_EN is undefined.
- f_empty  input  1  TX FIFO empty flag.
- rd_data  input  DATA_WIDTH  FIFO head entry, valid whenever f_empty=0 (show-ahead).
- rd_en  output  1  one-cycle FIFO pop strobe.
- txd  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight.
- tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async assert):
  - txd=1, rd_en=0, busy=0, tx_done=0.
  - state=IDLE; all counters and the shift register cleared.
  - A reset mid-frame aborts the frame immediately; no pop is issued.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Frame launch: on the edge where (IDLE or the last STOP cycle) and tx_en=1 and f_empty=0:
  - shift register <= rd_data;
  - divisor latched into div_q;
  - rd_en <= 1 for exactly one cycle (the FIFO pops on the following edge);
  - txd <= 0, busy <= 1, state <= START;
  - baud counter <= 0.
- Per-frame latching: divisor and parity_odd are sampled at launch only. Changes mid-frame have no effect until the next frame.
- Bit timing:
  - Each bit lasts div_q+1 cycles; the baud counter counts 0..div_q and then advances the bit.
  - div_q=0 gives 1-cycle bits.
- START: txd=0 for one bit period, then go to DATA with bit index 0.
- DATA: txd = shreg[0]; shift right at each bit end. After DATA_WIDTH bits go to PARITY if enabled, else STOP.
- PARITY: txd = XOR of the frame data XOR parity_odd, for one bit period.
- STOP:
  - txd=1 for STOP_BITS bit periods.
  - On the last cycle, tx_done pulses on the same edge as the exit transition.
  - Exit goes back-to-back to START if the launch condition holds (no idle cycle between frames).
  - Otherwise exit goes to IDLE with busy <= 0.
- tx_en deasserted mid-frame: the current frame completes unchanged. No new launch occurs while tx_en=0.
- f_empty=1 in IDLE: stay in IDLE; txd=1, rd_en=0.
- rd_en is never asserted when f_empty=0 was not observed on the launch edge. rd_en pulses at most once per frame.
- The bit index counter uses ceil(log2(DATA_WIDTH+1)) bits. The baud counter is DIV_WIDTH bits and never wraps past div_q.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is compiled in and one parity bit is inserted after the data bits.
  - Frame length = (1+DATA_WIDTH+1+STOP_BITS)*(div_q+1) cycles.
- Undefined:
  - PARITY state and parity logic are absent; parity_odd is unused.
  - Frame length = (1+DATA_WIDTH+STOP_BITS)*(div_q+1) cycles.

Test Plan:
- Single frame, no parity:
  - Stimulus: divisor=3, rd_data=0xA5, f_empty 1->0, tx_en=1.
  - Response: rd_en pulses once; txd holds each level for 4 cycles in the sequence 0,1,0,1,0,0,1,0,1,1; tx_done pulses 40 cycles after launch; busy falls.
- Parity, UART_TX_PARITY_EN defined:
  - Stimulus: 0xA5, divisor=3, once with parity_odd=0 and once with parity_odd=1.
  - Response: the parity bit is 0 for parity_odd=0 and 1 for parity_odd=1; the frame is 44 cycles.
- Back-to-back:
  - Stimulus: two entries 0x00 then 0xFF queued, divisor=1.
  - Response: rd_en pulses exactly twice, 20 cycles apart; no idle-high cycle beyond the stop bit between frames; tx_done pulses twice.
- Empty FIFO:
  - Stimulus: tx_en=1, f_empty=1 for 100 cycles.
  - Response: txd=1, rd_en=0, busy=0 throughout.
- Mid-frame tx_en drop and divisor change:
  - Stimulus: drop tx_en and change divisor 3->7 during DATA bit 2.
  - Response: the frame finishes with 4-cycle bits; no further rd_en while tx_en=0, even with f_empty=0.
- Reset mid-frame:
  - Stimulus: assert n_rst during DATA bit 4.
  - Response: txd=1, busy=0, rd_en=0 immediately. After release with f_empty=0 and tx_en=1, a new frame starts cleanly with a start bit.
